// File: rtl/mem_arbiter.sv
// Two-requester (CPU / display) read arbiter onto a single memory read port,
// with round-robin tie-break, per-read timeout and a registered write pass-through.
module mem_arbiter #(
    parameter int ADDR_W  = 12,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_read,
    input  logic [ADDR_W-1:0] cpu_read_addr,
    output logic [7:0]        cpu_read_data,
    output logic              cpu_read_ack,
    input  logic              vid_read,
    input  logic [ADDR_W-1:0] vid_read_addr,
    output logic [7:0]        vid_read_data,
    output logic              vid_read_ack,
    input  logic              cpu_write,
    input  logic [ADDR_W-1:0] cpu_write_addr,
    input  logic [7:0]        cpu_write_data,
    output logic              mem_read,
    output logic [ADDR_W-1:0] mem_read_addr,
    input  logic [7:0]        mem_read_data,
    input  logic              mem_read_ack,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_write_addr,
    output logic [7:0]        mem_write_data,
    output logic              busy,
    output logic              err,
    input  logic              err_clr
);

    typedef enum logic [1:0] {IDLE, WAIT_CPU, WAIT_VID} state_t;

    // Counter starts at 0 the cycle after grant, so this yields TIMEOUT wait cycles.
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    state_t            state;
    logic              cpu_pend, vid_pend;
    logic [ADDR_W-1:0] cpu_addr, vid_addr;
    logic [7:0]        cnt;
    logic              last_vid;

    logic              cpu_req, vid_req, grant_cpu, grant_vid, expired;
    logic [ADDR_W-1:0] cpu_eff, vid_eff;

    // A pulse arriving in IDLE is granted directly, bypassing the slot register.
    assign cpu_req   = cpu_pend | cpu_read;
    assign vid_req   = vid_pend | vid_read;
    assign cpu_eff   = cpu_pend ? cpu_addr : cpu_read_addr;
    assign vid_eff   = vid_pend ? vid_addr : vid_read_addr;
    assign grant_cpu = cpu_req & (~vid_req | last_vid);
    assign grant_vid = vid_req & ~grant_cpu;
    assign expired   = ~mem_read_ack & (cnt == TO_LAST);
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            cpu_pend       <= 1'b0;
            vid_pend       <= 1'b0;
            cpu_addr       <= '0;
            vid_addr       <= '0;
            cnt            <= '0;
            last_vid       <= 1'b1;
            mem_read       <= 1'b0;
            mem_read_addr  <= '0;
            mem_write      <= 1'b0;
            mem_write_addr <= '0;
            mem_write_data <= '0;
            cpu_read_data  <= '0;
            cpu_read_ack   <= 1'b0;
            vid_read_data  <= '0;
            vid_read_ack   <= 1'b0;
            err            <= 1'b0;
        end else begin
            mem_read     <= 1'b0;
            cpu_read_ack <= 1'b0;
            vid_read_ack <= 1'b0;

            mem_write <= cpu_write;
            if (cpu_write) begin
                mem_write_addr <= cpu_write_addr;
                mem_write_data <= cpu_write_data;
            end

            if (cpu_read && !cpu_pend) begin
                cpu_pend <= 1'b1;
                cpu_addr <= cpu_read_addr;
            end
            if (vid_read && !vid_pend) begin
                vid_pend <= 1'b1;
                vid_addr <= vid_read_addr;
            end

            // A timeout below overrides a simultaneous clear.
            if (err_clr) err <= 1'b0;

            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (grant_cpu) begin
                        mem_read      <= 1'b1;
                        mem_read_addr <= cpu_eff;
                        last_vid      <= 1'b0;
                        state         <= WAIT_CPU;
                    end else if (grant_vid) begin
                        mem_read      <= 1'b1;
                        mem_read_addr <= vid_eff;
                        last_vid      <= 1'b1;
                        state         <= WAIT_VID;
                    end
                end
                WAIT_CPU: begin
                    if (mem_read_ack || expired) begin
                        cpu_read_data <= mem_read_ack ? mem_read_data : 8'hFF;
                        cpu_read_ack  <= 1'b1;
                        cpu_pend      <= 1'b0;
                        cnt           <= '0;
                        state         <= IDLE;
                        if (expired) err <= 1'b1;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                WAIT_VID: begin
                    if (mem_read_ack || expired) begin
                        vid_read_data <= mem_read_ack ? mem_read_data : 8'hFF;
                        vid_read_ack  <= 1'b1;
                        vid_pend      <= 1'b0;
                        cnt           <= '0;
                        state         <= IDLE;
                        if (expired) err <= 1'b1;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: grants, round-robin, timeout, write path, reset.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cpu_read, vid_read, cpu_write, mem_read_ack, err_clr;
    logic [11:0] cpu_read_addr, vid_read_addr, cpu_write_addr;
    logic [7:0]  cpu_write_data, mem_read_data;
    logic [7:0]  cpu_read_data, vid_read_data, mem_write_data;
    logic        cpu_read_ack, vid_read_ack, mem_read, mem_write, busy, err;
    logic [11:0] mem_read_addr, mem_write_addr;

    int tests = 0;
    int fails = 0;

    mem_arbiter #(.ADDR_W(12), .TIMEOUT(15)) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_read(cpu_read), .cpu_read_addr(cpu_read_addr),
        .cpu_read_data(cpu_read_data), .cpu_read_ack(cpu_read_ack),
        .vid_read(vid_read), .vid_read_addr(vid_read_addr),
        .vid_read_data(vid_read_data), .vid_read_ack(vid_read_ack),
        .cpu_write(cpu_write), .cpu_write_addr(cpu_write_addr),
        .cpu_write_data(cpu_write_data),
        .mem_read(mem_read), .mem_read_addr(mem_read_addr),
        .mem_read_data(mem_read_data), .mem_read_ack(mem_read_ack),
        .mem_write(mem_write), .mem_write_addr(mem_write_addr),
        .mem_write_data(mem_write_data),
        .busy(busy), .err(err), .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        cpu_read = 0; vid_read = 0; cpu_write = 0; mem_read_ack = 0; err_clr = 0;
        cpu_read_addr = '0; vid_read_addr = '0; cpu_write_addr = '0;
        cpu_write_data = '0; mem_read_data = '0;
        #12;
        chk("rst_mem_read", 32'(mem_read), 0);
        chk("rst_mem_write", 32'(mem_write), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_acks", 32'({cpu_read_ack, vid_read_ack}), 0);
        chk("rst_rd_addr", 32'(mem_read_addr), 0);
        rst_n = 1'b1;
        tick();

        // First tie after reset: CPU wins, VID follows
        cpu_read = 1; cpu_read_addr = 12'h010; vid_read = 1; vid_read_addr = 12'h300;
        tick();
        cpu_read = 0; vid_read = 0;
        chk("tie1_first_rd", 32'(mem_read), 1);
        chk("tie1_first_addr", 32'(mem_read_addr), 32'h010);
        chk("tie1_busy", 32'(busy), 1);
        mem_read_ack = 1; mem_read_data = 8'h11;
        tick();
        mem_read_ack = 0;
        chk("tie1_cpu_ack", 32'(cpu_read_ack), 1);
        chk("tie1_cpu_data", 32'(cpu_read_data), 32'h11);
        chk("tie1_rd_pulse", 32'(mem_read), 0);
        tick();
        chk("tie1_second_rd", 32'(mem_read), 1);
        chk("tie1_second_addr", 32'(mem_read_addr), 32'h300);
        chk("tie1_cpu_ack_off", 32'(cpu_read_ack), 0);
        mem_read_ack = 1; mem_read_data = 8'h22;
        tick();
        mem_read_ack = 0;
        chk("tie1_vid_ack", 32'(vid_read_ack), 1);
        chk("tie1_vid_data", 32'(vid_read_data), 32'h22);

        // Single CPU read, ack two cycles after mem_read
        cpu_read = 1; cpu_read_addr = 12'h200;
        tick();
        cpu_read = 0;
        chk("cpu_rd", 32'(mem_read), 1);
        chk("cpu_rd_addr", 32'(mem_read_addr), 32'h200);
        tick();
        chk("cpu_rd_one_cycle", 32'(mem_read), 0);
        chk("cpu_addr_hold", 32'(mem_read_addr), 32'h200);
        tick();
        mem_read_ack = 1; mem_read_data = 8'hA5;
        tick();
        mem_read_ack = 0;
        chk("cpu_ack", 32'(cpu_read_ack), 1);
        chk("cpu_data", 32'(cpu_read_data), 32'hA5);
        chk("cpu_vid_ack_quiet", 32'(vid_read_ack), 0);
        chk("cpu_vid_data_kept", 32'(vid_read_data), 32'h22);
        chk("cpu_idle", 32'(busy), 0);
        tick();
        chk("cpu_ack_single", 32'(cpu_read_ack), 0);
        chk("cpu_data_hold", 32'(cpu_read_data), 32'hA5);

        // Tie with CPU granted last: VID wins
        cpu_read = 1; cpu_read_addr = 12'h011; vid_read = 1; vid_read_addr = 12'h301;
        tick();
        cpu_read = 0; vid_read = 0;
        chk("tie2_first_addr", 32'(mem_read_addr), 32'h301);
        mem_read_ack = 1; mem_read_data = 8'h33;
        tick();
        mem_read_ack = 0;
        chk("tie2_vid_ack", 32'(vid_read_ack), 1);
        chk("tie2_vid_data", 32'(vid_read_data), 32'h33);
        tick();
        chk("tie2_second_rd", 32'(mem_read), 1);
        chk("tie2_second_addr", 32'(mem_read_addr), 32'h011);
        mem_read_ack = 1; mem_read_data = 8'h44;
        tick();
        mem_read_ack = 0;
        chk("tie2_cpu_data", 32'(cpu_read_data), 32'h44);

        // VID timeout, then err_clr
        vid_read = 1; vid_read_addr = 12'h123;
        tick();
        vid_read = 0;
        for (int i = 1; i <= 14; i++) tick();
        chk("to_no_ack_early", 32'(vid_read_ack), 0);
        chk("to_busy_early", 32'(busy), 1);
        chk("to_err_early", 32'(err), 0);
        tick();
        chk("to_ack", 32'(vid_read_ack), 1);
        chk("to_data", 32'(vid_read_data), 32'hFF);
        chk("to_err", 32'(err), 1);
        chk("to_idle", 32'(busy), 0);
        tick();
        chk("to_err_sticky", 32'(err), 1);
        chk("to_ack_single", 32'(vid_read_ack), 0);
        err_clr = 1;
        tick();
        err_clr = 0;
        chk("to_err_cleared", 32'(err), 0);

        // Timeout coinciding with err_clr keeps err set
        vid_read = 1; vid_read_addr = 12'h124;
        tick();
        vid_read = 0;
        for (int i = 1; i <= 14; i++) tick();
        err_clr = 1;
        tick();
        chk("to2_ack", 32'(vid_read_ack), 1);
        chk("to2_err_wins", 32'(err), 1);
        tick();
        err_clr = 0;
        chk("to2_err_cleared", 32'(err), 0);

        // Write forwarded while a VID read waits
        vid_read = 1; vid_read_addr = 12'h0F0;
        tick();
        vid_read = 0;
        cpu_write = 1; cpu_write_addr = 12'h050; cpu_write_data = 8'h3C;
        tick();
        cpu_write = 0;
        chk("wr_pulse", 32'(mem_write), 1);
        chk("wr_addr", 32'(mem_write_addr), 32'h050);
        chk("wr_data", 32'(mem_write_data), 32'h3C);
        chk("wr_busy", 32'(busy), 1);
        tick();
        chk("wr_one_cycle", 32'(mem_write), 0);
        mem_read_ack = 1; mem_read_data = 8'h5A;
        tick();
        mem_read_ack = 0;
        chk("wr_vid_ack", 32'(vid_read_ack), 1);
        chk("wr_vid_data", 32'(vid_read_data), 32'h5A);

        // Second CPU pulse while pending is dropped
        vid_read = 1; vid_read_addr = 12'h400;
        tick();
        vid_read = 0;
        cpu_read = 1; cpu_read_addr = 12'h222;
        tick();
        cpu_read_addr = 12'h111;
        tick();
        cpu_read = 0;
        mem_read_ack = 1; mem_read_data = 8'h66;
        tick();
        mem_read_ack = 0;
        chk("pend_vid_data", 32'(vid_read_data), 32'h66);
        tick();
        chk("pend_cpu_rd", 32'(mem_read), 1);
        chk("pend_cpu_addr", 32'(mem_read_addr), 32'h222);
        mem_read_ack = 1; mem_read_data = 8'h77;
        tick();
        mem_read_ack = 0;
        chk("pend_cpu_ack", 32'(cpu_read_ack), 1);
        chk("pend_cpu_data", 32'(cpu_read_data), 32'h77);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("pend_no_rd", 32'(mem_read), 0);
            chk("pend_no_ack", 32'(cpu_read_ack), 0);
        end
        chk("pend_addr_hold", 32'(mem_read_addr), 32'h222);

        // Reset mid-read, then late ack
        cpu_read = 1; cpu_read_addr = 12'h0AB;
        tick();
        cpu_read = 0;
        tick();
        chk("mid_busy", 32'(busy), 1);
        rst_n = 0;
        #2;
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_addr", 32'(mem_read_addr), 0);
        chk("mid_rst_cpu_data", 32'(cpu_read_data), 0);
        chk("mid_rst_vid_data", 32'(vid_read_data), 0);
        rst_n = 1;
        tick();
        mem_read_ack = 1; mem_read_data = 8'h99;
        tick();
        mem_read_ack = 0;
        chk("late_no_ack", 32'(cpu_read_ack), 0);
        chk("late_data", 32'(cpu_read_data), 0);
        chk("late_busy", 32'(busy), 0);
        chk("late_no_rd", 32'(mem_read), 0);
        tick();
        chk("late_no_ack2", 32'(cpu_read_ack), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 12, memory address width in bits.
REQ-002 SHALL have parameter TIMEOUT, default 15, number of wait cycles before an unanswered read is abandoned (legal range 1..255).
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have ports cpu_read input 1, cpu_read_addr input ADDR_W, cpu_read_data output 8, cpu_read_ack output 1, for CPU read requests.
REQ-006 SHALL have ports vid_read input 1, vid_read_addr input ADDR_W, vid_read_data output 8, vid_read_ack output 1, for display-engine read requests.
REQ-007 SHALL have ports cpu_write input 1, cpu_write_addr input ADDR_W, cpu_write_data input 8, for CPU writes.
REQ-008 SHALL have ports mem_read output 1, mem_read_addr output ADDR_W, mem_read_data input 8, mem_read_ack input 1, to the memory read port.
REQ-009 SHALL have ports mem_write output 1, mem_write_addr output ADDR_W, mem_write_data output 8, to the memory write port.
REQ-010 SHALL have ports busy output 1 (read in flight), err output 1 (sticky timeout flag), err_clr input 1 (clears err).

Function
REQ-011 Read requests SHALL be one-cycle pulses on cpu_read/vid_read with address valid in the same cycle; the block SHALL latch address into a per-requester pending slot.
REQ-012 A request pulse from a requester whose slot is already pending SHALL be ignored (address not overwritten).
REQ-013 State machine SHALL have states IDLE, WAIT_CPU, WAIT_VID; reset state IDLE.
REQ-014 In IDLE with exactly one requester pending (or pulsing this cycle), SHALL grant it; with both, SHALL grant the requester not granted last (round-robin); last-grant resets to VID so CPU wins the first tie.
REQ-015 On grant, mem_read SHALL be high for exactly one cycle with mem_read_addr = granted address; minimum latency request pulse -> mem_read high = 1 cycle.
REQ-016 mem_read_addr SHALL hold its value until the next grant; mem_read SHALL never be high outside the cycle following a grant.
REQ-017 In WAIT_x, an 8-bit wait counter SHALL increment each cycle from 0; when mem_read_ack is high, mem_read_data SHALL be captured into x_read_data, x_read_ack pulsed high for one cycle on the next cycle, slot x cleared, state -> IDLE.
REQ-018 If counter reaches TIMEOUT with no mem_read_ack, SHALL load x_read_data = 8'hFF, pulse x_read_ack, set err, clear slot x, state -> IDLE.
REQ-019 mem_read_ack received in IDLE (late ack) SHALL be ignored and SHALL not affect any output.
REQ-020 x_read_data SHALL hold its last value until the next ack to that requester.
REQ-021 A new grant SHALL be possible in the cycle after the requester ack pulse (back-to-back throughput one read per ack latency + 2 cycles).
REQ-022 cpu_write pulse SHALL be forwarded registered: mem_write/addr/data equal the inputs one cycle later, mem_write high exactly one cycle, independent of read state.
REQ-023 busy SHALL be high whenever state != IDLE.
REQ-024 err SHALL stay set until err_clr is sampled high; simultaneous timeout and err_clr SHALL leave err set.

Reset
REQ-025 On rst_n low, asynchronously: state IDLE, pending slots cleared, counter 0, last-grant VID, mem_read 0, mem_write 0, all ack outputs 0, busy 0, err 0, all data/address outputs 0.
REQ-026 Reset mid-read SHALL abandon the read with no requester ack; a later mem_read_ack SHALL be ignored per REQ-019.

Verification
REQ-027 CPU pulse addr 12'h200, memory acks 2 cycles after mem_read with 8'hA5 -> mem_read one cycle with addr 12'h200, cpu_read_ack one pulse, cpu_read_data 8'hA5, vid untouched.
REQ-028 CPU (12'h010) and VID (12'h300) pulse same cycle after reset -> CPU granted first, VID second; repeat tie -> VID first.
REQ-029 VID pulse, memory never acks -> after TIMEOUT=15 cycles vid_read_ack pulses with 8'hFF, err=1; err_clr pulse -> err=0.
REQ-030 cpu_write addr 12'h050 data 8'h3C during WAIT_VID -> mem_write one cycle later with 12'h050/8'h3C; read completes normally.
REQ-031 Assert rst_n low while WAIT_CPU, release, then drive late mem_read_ack -> no cpu_read_ack, busy=0, outputs at reset values.
REQ-032 Second CPU pulse (12'h111) while first (12'h222) pending -> only 12'h222 read issued, one ack.
